serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer for area-constrained datapath variants. It time-multiplexes a single 1-bit full adder cell across all WIDTH operand bits, LSB first, over WIDTH cycles. It owns operand shifting, carry storage, subtract inversion and the start/done handshake, and presents a parallel result plus carry and overflow flags to the surrounding datapath.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_add_ctrl_fa.sv | 14 +
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Holds the FSM state encoding and the legal WIDTH range check.
package serial_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    localparam int unsigned WidthMin = 2;
    localparam int unsigned WidthMax = 64;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WidthMin) && (w <= WidthMax);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// FA_1bit: single-bit full adder cell.
// Ports: a_i, b_i, cin_i operand/carry inputs; sum_o sum bit; cout_o carry out.
module FA_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer, LSB first, one bit per cycle
// through a single FA_1bit cell.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start, sub       request and operation select (0 = a+b, 1 = a-b), sampled in IDLE/DONE
//   a, b             operands, sampled with start
//   busy             high while bits are being processed
//   done             one-cycle pulse when result/cout/overflow are valid
//   result           result shift register (only meaningful on/after done)
//   cout, overflow   carry out of MSB and signed overflow of the last operation
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    if (!width_ok(WIDTH)) begin : gen_width_check
        $error("serial_add_ctrl: WIDTH out of range 2..64");
    end

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum;
    logic fa_cout;
    logic cin_msb;

    FA_1bit u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .cin_i (carry_q),
        .sum_o (fa_sum),
        .cout_o(fa_cout)
    );

    // On the last bit the carry flop holds the carry into the MSB.
    assign cin_msb = carry_q;

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    a_sr_d   = a;
                    // Subtract as a + ~b + 1: invert b and seed the carry.
                    b_sr_d   = sub ? ~b : b;
                    carry_d  = sub;
                    cnt_d    = '0;
                    res_sr_d = '0;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                carry_d  = fa_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                if (cnt_q == LastBit) begin
                    // Hold the counter so it never wraps for power-of-two widths.
                    cout_d  = fa_cout;
                    ovf_d   = cin_msb ^ fa_cout;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign result   = res_sr_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain two's-complement arithmetic. Returns {overflow, cout, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic sv);
        int unsigned full;
        int          sa, sb, sr;
        logic [W-1:0] r;
        logic        c, o;
        sa = (av >= 128) ? int'(av) - 256 : int'(av);
        sb = (bv >= 128) ? int'(bv) - 256 : int'(bv);
        if (sv) begin
            full = int'(av) + 256 - int'(bv);
            sr   = sa - sb;
        end else begin
            full = int'(av) + int'(bv);
            sr   = sa + sb;
        end
        r = full[W-1:0];
        c = (full >= 256);
        o = (sr > 127) || (sr < -128);
        return {o, c, r};
    endfunction

    // Issues one operation and waits for done. lat counts edges from the start edge (E0).
    // pulse_at > 0 pulses start (with junk operands) at that point during RUN.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input int pulse_at, output int lat, output int busy_cyc,
                          output bit to);
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cyc = 0; to = 1'b0;
        while (!done) begin
            if (busy) busy_cyc++;
            if (lat == pulse_at) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (lat > 40) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        n_tests++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
                     busy, done, result, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
        logic [W-1:0] vb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [4] = '{8'h80, 8'h00, 8'hFE, 8'h7F};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat, bc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], 0, lat, bc, to);
            n_tests++;
            if (to || lat != W + 1 || bc != W) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d to=%b want lat=%0d busy=%0d",
                         i, lat, bc, to, W + 1, W);
            end
            n_tests++;
            if ({result, cout, overflow} !== {er[i], ec[i], eo[i]}) begin
                n_fail++;
                $display("FAIL directed_value[%0d]: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                         i, result, cout, overflow, er[i], ec[i], eo[i]);
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || result !== er[i]) begin
                n_fail++;
                $display("FAIL directed_pulse_hold[%0d]: got done=%b r=%h want done=0 r=%h",
                         i, done, result, er[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc;
        bit to;
        logic [W-1:0] av, bv;
        logic sv;
        logic [W+1:0] exp;
        for (int i = 0; i < 40; i++) begin
            av = W'($urandom); bv = W'($urandom); sv = 1'($urandom);
            exp = model(av, bv, sv);
            run_op(av, bv, sv, 0, lat, bc, to);
            n_tests++;
            if (to || lat != W + 1 || {overflow, cout, result} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] %h %s %h: got o,c,r=%b,%b,%h lat=%0d want %b,%b,%h lat=%0d",
                         i, av, sv ? "-" : "+", bv, overflow, cout, result, lat,
                         exp[W+1], exp[W], exp[W-1:0], W + 1);
            end
        end
    endtask

    task automatic test_mid_run_start();
        int lat, bc;
        bit to;
        logic [W+1:0] exp;
        exp = model(8'h3C, 8'h29, 1'b0);
        run_op(8'h3C, 8'h29, 1'b0, 3, lat, bc, to);
        n_tests++;
        if (to || lat != W + 1 || {overflow, cout, result} !== exp) begin
            n_fail++;
            $display("FAIL mid_run_start: got o,c,r=%b,%b,%h lat=%0d want %b,%b,%h lat=%0d",
                     overflow, cout, result, lat, exp[W+1], exp[W], exp[W-1:0], W + 1);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_no_queue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_flag_hold();
        int lat, bc;
        bit to;
        run_op(8'h7F, 8'h01, 1'b0, 0, lat, bc, to);  // leaves overflow=1, cout=0
        @(negedge clk);
        a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || cout !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL flag_hold: got busy=%b c=%b o=%b want 1 0 1", busy, cout, overflow);
        end
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || {result, cout, overflow} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flag_hold_final: got done=%b r=%h c=%b o=%b want 1 00 1 0",
                     done, result, cout, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || result !== 8'h80 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b busy=%b r=%h lat=%0d want 1 0 80",
                     done, busy, result, lat);
        end
        a = 8'h05; b = 8'h07; sub = 1'b1; start = 1'b1;  // sampled in DONE
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b want 1 0", busy, done);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        n_tests++;
        if (lat != W + 1 || done !== 1'b1 || {result, cout, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d r=%h c=%b o=%b want lat=%0d r=fe c=0 o=0",
                     lat, result, cout, overflow, W + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        bit to, saw;
        run_op(8'h80, 8'h01, 1'b1, 0, lat, bc, to);  // flags 1/1 before the reset
        @(negedge clk);
        a = 8'h55; b = 8'h22; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);  // E4: bits 0..3 done, bit 4 in progress
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b r=%h c=%b o=%b want all 0",
                     busy, done, result, cout, overflow);
        end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got activity=%b want 0", saw);
        end
        run_op(8'h12, 8'h34, 1'b0, 0, lat, bc, to);
        n_tests++;
        if (to || lat != W + 1 || {result, cout, overflow} !== {8'h46, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_recover: got r=%h c=%b o=%b lat=%0d want 46 0 0 lat=%0d",
                     result, cout, overflow, lat, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mid_run_start();
        test_flag_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
